// File: rtl/lab7_soc_switch_ctrl.sv
// rtl/lab7_soc_switch_ctrl.sv - debounced slide-switch Avalon-MM slave with rising-edge capture and IRQ
module lab7_soc_switch_ctrl #(
    parameter int WIDTH     = 12,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CNT  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] A_DATA    = 2'd0;
    localparam logic [1:0] A_IRQMASK = 2'd1;
    localparam logic [1:0] A_CTRL    = 2'd2;
    localparam logic [1:0] A_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] db_val;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic             ctrl_en;

    logic [WIDTH-1:0] cand_nxt;
    logic [WIDTH-1:0] db_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0]      rd_mux;
    logic             wr_en;

    // Only the low WIDTH bits of writedata reach any register.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en    = chipselect & write;
    assign w1c_mask = (wr_en && address == A_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign rise     = db_nxt & ~db_val;
    assign irq      = |(edgecap & irqmask);

    // Debounce decision for the whole vector; bypass copies the synchronised input straight through.
    always_comb begin
        cand_nxt  = cand;
        db_nxt    = db_val;
        cnt_nxt   = cnt;
        state_nxt = state;
        if (!ctrl_en) begin
            db_nxt    = sync2;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = '0;
                    if (sync2 != db_val) begin
                        cand_nxt  = sync2;
                        state_nxt = ST_CNT;
                    end
                end
                default: begin
                    if (sync2 != cand) begin
                        cand_nxt = sync2;
                        cnt_nxt  = '0;
                    end else if (cnt == CNT_LAST) begin
                        db_nxt    = cand;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Read mux, zero-extended to the 32-bit bus.
    always_comb begin
        rd_mux = '0;
        case (address)
            A_DATA:    rd_mux[WIDTH-1:0] = db_val;
            A_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            A_CTRL:    rd_mux[0]         = ctrl_en;
            default:   rd_mux[WIDTH-1:0] = edgecap;
        endcase
    end

    // Two-flop synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            db_val <= '0;
            cnt    <= '0;
            state  <= ST_IDLE;
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            cand   <= cand_nxt;
            db_val <= db_nxt;
            cnt    <= cnt_nxt;
            state  <= state_nxt;
        end
    end

    // Bus-visible registers; a new rise beats a simultaneous W1C of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask  <= '0;
            edgecap  <= '0;
            ctrl_en  <= 1'b1;
            readdata <= '0;
        end else begin
            edgecap  <= (edgecap & ~w1c_mask) | rise;
            readdata <= rd_mux;
            if (wr_en && address == A_IRQMASK) irqmask <= writedata[WIDTH-1:0];
            if (wr_en && address == A_CTRL)    ctrl_en <= writedata[0];
        end
    end

endmodule

// File: tb/tb_lab7_soc_switch_ctrl.sv
// tb/tb_lab7_soc_switch_ctrl.sv - directed self-checking bench for lab7_soc_switch_ctrl
module tb_lab7_soc_switch_ctrl;

    localparam int DB = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [11:0] in_port;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    lab7_soc_switch_ctrl #(.WIDTH(12), .DB_CYCLES(DB), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b0;
        address    = a;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        int first;
        logic [31:0] d;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 2'd0;
        writedata = '0; in_port = 12'hA5A;
        tick(2);
        n_assert++;
        if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want %h", readdata, 32'h0); end
        n_assert++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        reset = 1'b0;
        first = 0;
        for (int n = 1; n <= DB + 20; n++) begin
            @(negedge clk);
            if (first == 0 && readdata === 32'h0000_0A5A) first = n;
        end
        n_assert++;
        if (first !== DB + 4) begin n_fail++; $display("FAIL reset_commit_cycle got %0d want %0d", first, DB + 4); end
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0000_0A5A) begin n_fail++; $display("FAIL reset_edgecap got %h want %h", d, 32'h0A5A); end
    endtask

    task automatic test_bounce;
        int bad;
        int first;
        logic [31:0] d;
        address = 2'd0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            in_port[0] = ~in_port[0];
            tick(10);
            if (readdata[0] !== 1'b0) bad++;
        end
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL bounce_stable got %0d early changes want 0", bad); end
        in_port[0] = 1'b1;
        first = 0;
        for (int n = 1; n <= DB + 20; n++) begin
            @(negedge clk);
            if (first == 0 && readdata[0] === 1'b1) first = n;
        end
        n_assert++;
        if (first !== DB + 4) begin n_fail++; $display("FAIL bounce_commit_cycle got %0d want %0d", first, DB + 4); end
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0000_0A5B) begin n_fail++; $display("FAIL bounce_edgecap got %h want %h", d, 32'h0A5B); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        reg_write(2'd2, 32'h0);
        in_port = 12'h000;
        tick(5);
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0000_0A5B) begin n_fail++; $display("FAIL irq_no_fall_capture got %h want %h", d, 32'h0A5B); end
        reg_write(2'd3, 32'hFFFF_FFFF);
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL irq_w1c_all got %h want 0", d); end
        reg_write(2'd1, 32'h0000_0001);
        in_port = 12'h001;
        tick(2);
        n_assert++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq); end
        tick(1);
        n_assert++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_bit0_rise got %b want 1", irq); end
        reg_write(2'd3, 32'h0000_0001);
        n_assert++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_clear got %b want 0", irq); end
        in_port = 12'h003;
        tick(5);
        n_assert++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked_bit1 got %b want 0", irq); end
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL irq_edgecap_bit1 got %h want %h", d, 32'h2); end
    endtask

    task automatic test_w1c_race;
        logic [31:0] d;
        in_port = 12'h00B;
        tick(2);
        reg_write(2'd3, 32'h0000_000A);
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL w1c_race got %h want %h", d, 32'h8); end
    endtask

    task automatic test_bypass;
        logic [31:0] d;
        int first;
        in_port = 12'h000;
        tick(5);
        reg_write(2'd3, 32'h0000_0FFF);
        reg_write(2'd1, 32'h0000_0FFF);
        address = 2'd0;
        tick(1);
        in_port = 12'h0F0;
        tick(2);
        n_assert++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin n_fail++; $display("FAIL bypass_early got irq=%b data=%h want 0/0", irq, readdata); end
        tick(1);
        n_assert++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL bypass_irq_3clk got %b want 1", irq); end
        tick(1);
        n_assert++;
        if (readdata !== 32'h0000_00F0) begin n_fail++; $display("FAIL bypass_data got %h want %h", readdata, 32'hF0); end
        reg_write(2'd3, 32'h0000_0FFF);
        reg_write(2'd2, 32'h0000_0001);
        in_port = 12'h0FF;
        tick(30);
        in_port = 12'h0F0;
        tick(1);
        reg_write(2'd2, 32'h0);
        address = 2'd0;
        tick(DB + 50);
        n_assert++;
        if (readdata !== 32'h0000_00F0) begin n_fail++; $display("FAIL abort_data got %h want %h", readdata, 32'hF0); end
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL abort_no_commit got edgecap=%h irq=%b want 0/0", d, irq); end
        reg_write(2'd2, 32'h0000_0001);
        address = 2'd0;
        in_port = 12'h00F;
        first = 0;
        for (int n = 1; n <= DB + 20; n++) begin
            @(negedge clk);
            if (first == 0 && readdata === 32'h0000_000F) first = n;
        end
        n_assert++;
        if (first !== DB + 4) begin n_fail++; $display("FAIL reenable_commit_cycle got %0d want %0d", first, DB + 4); end
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0000_000F) begin n_fail++; $display("FAIL reenable_edgecap got %h want %h", d, 32'hF); end
    endtask

    task automatic test_reset_mid_cnt;
        logic [31:0] d;
        n_assert++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        in_port = 12'hFFF;
        tick(20);
        reset = 1'b1;
        address = 2'd2;
        tick(1);
        n_assert++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin n_fail++; $display("FAIL midcnt_reset got irq=%b data=%h want 0/0", irq, readdata); end
        reset = 1'b0;
        tick(1);
        n_assert++;
        if (readdata !== 32'h0000_0001) begin n_fail++; $display("FAIL midcnt_ctrl got %h want %h", readdata, 32'h1); end
        reg_read(2'd1, d);
        n_assert++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midcnt_irqmask got %h want 0", d); end
        reg_read(2'd3, d);
        n_assert++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midcnt_edgecap got %h want 0", d); end
        reg_read(2'd0, d);
        n_assert++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midcnt_data got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_irq();
        test_w1c_race();
        test_bypass();
        test_reset_mid_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
